retry_scheduler: RTL and testbench

RETRY_SCHEDULER -- requirements
Module: retry_scheduler

---
 rtl/retry_scheduler.sv | 154 +++++++++++++++
 tb/tb_retry_scheduler.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/retry_scheduler.sv
// Retry scheduler: bounds how often each transfer ID may be retried through a pipeline.
//
// Retry requests from the pipeline end are checked against a per-ID retry budget. Requests
// within budget (or any request while limiting is disabled) are queued in order and replayed
// toward the pipeline start. Requests over budget are dropped and reported, and a sticky
// fatal flag is raised. A fresh issue of an ID restores its full budget.
//
// Ports:
//   clk_i, rst_ni                  clock, synchronous active-low reset
//   enable_i                       1 = retry limiting active, 0 = queue everything
//   issue_id_i / issue_valid_i     fresh issue, resets that ID's retry counter
//   retry_id_i / retry_valid_i /   incoming retry request (ready = queue not full)
//   retry_ready_o
//   retry_id_o / retry_valid_o /   scheduled retry toward the pipeline start
//   retry_ready_i
//   drop_id_o / drop_valid_o       one-cycle report of an over-budget retry
//   fatal_o / clear_i              sticky drop flag and its clear
//   pending_o                      queue occupancy
module retry_scheduler #(
   parameter int unsigned IDSize     = 4,
   parameter int unsigned MaxRetries = 3,
   parameter int unsigned FifoDepth  = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       enable_i,
   input  logic [IDSize-1:0]          issue_id_i,
   input  logic                       issue_valid_i,
   input  logic [IDSize-1:0]          retry_id_i,
   input  logic                       retry_valid_i,
   output logic                       retry_ready_o,
   output logic [IDSize-1:0]          retry_id_o,
   output logic                       retry_valid_o,
   input  logic                       retry_ready_i,
   output logic [IDSize-1:0]          drop_id_o,
   output logic                       drop_valid_o,
   output logic                       fatal_o,
   input  logic                       clear_i,
   output logic [$clog2(FifoDepth):0] pending_o
);

   localparam int unsigned NumIds = 2 ** IDSize;
   localparam int unsigned CntW   = $clog2(MaxRetries + 1);
   localparam int unsigned PtrW   = $clog2(FifoDepth);
   localparam int unsigned OccW   = PtrW + 1;

   localparam logic [CntW-1:0] MaxCnt   = CntW'(MaxRetries);
   localparam logic [OccW-1:0] DepthOcc = OccW'(FifoDepth);

   logic [CntW-1:0]   cnt_q [NumIds];
   logic [CntW-1:0]   cnt_d [NumIds];
   logic [IDSize-1:0] mem_q [FifoDepth];
   logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [OccW-1:0]   occ_q, occ_d;
   logic              drop_valid_q, drop_valid_d;
   logic [IDSize-1:0] drop_id_q, drop_id_d;
   logic              fatal_q, fatal_d;

   logic              full, empty;
   logic              accept, pop, push, drop, collide, at_limit;
   logic [CntW-1:0]   cur_cnt;

   // Full is taken from the registered occupancy only, so a pop in the same cycle
   // never makes room for a push.
   assign full    = (occ_q == DepthOcc);
   assign empty   = (occ_q == '0);
   assign accept  = retry_valid_i && !full;
   assign pop     = !empty && retry_ready_i;
   assign collide = issue_valid_i && accept && (issue_id_i == retry_id_i);
   assign cur_cnt = cnt_q[retry_id_i];
   assign at_limit = (cur_cnt >= MaxCnt);

   // A retry colliding with a fresh issue of the same ID belongs to the new issue,
   // so it is always queued and never charged against the budget.
   assign push = accept && (collide || !enable_i || !at_limit);
   assign drop = accept && enable_i && !collide && at_limit;

   always_comb begin
      cnt_d = cnt_q;
      if (accept && enable_i && !collide && !at_limit) begin
         cnt_d[retry_id_i] = cur_cnt + 1'b1;
      end
      // Issue reset is applied last so it wins over any increment to the same ID.
      if (issue_valid_i) begin
         cnt_d[issue_id_i] = '0;
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      unique case ({push, pop})
         2'b10:   occ_d = occ_q + 1'b1;
         2'b01:   occ_d = occ_q - 1'b1;
         default: occ_d = occ_q;
      endcase
   end

   always_comb begin
      drop_valid_d = drop;
      drop_id_d    = drop ? retry_id_i : drop_id_q;
      fatal_d      = fatal_q;
      if (drop) begin
         fatal_d = 1'b1;
      end else if (clear_i) begin
         fatal_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int i = 0; i < NumIds; i++) begin
            cnt_q[i] <= '0;
         end
         for (int i = 0; i < FifoDepth; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         occ_q        <= '0;
         drop_valid_q <= 1'b0;
         drop_id_q    <= '0;
         fatal_q      <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         if (push) begin
            mem_q[wr_ptr_q] <= retry_id_i;
         end
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         occ_q        <= occ_d;
         drop_valid_q <= drop_valid_d;
         drop_id_q    <= drop_id_d;
         fatal_q      <= fatal_d;
      end
   end

   assign retry_ready_o = !full;
   assign retry_valid_o = !empty;
   assign retry_id_o    = mem_q[rd_ptr_q];
   assign drop_valid_o  = drop_valid_q;
   assign drop_id_o     = drop_id_q;
   assign fatal_o       = fatal_q;
   assign pending_o     = occ_q;

endmodule

// File: tb/tb_retry_scheduler.sv
// Bench for retry_scheduler: directed scenarios plus a randomized run against a
// queue-based reference model of the retry budget and replay queue.
module tb_retry_scheduler;

   localparam int IDS   = 4;
   localparam int MAXR  = 3;
   localparam int DEPTH = 4;

   logic           clk = 1'b0;
   logic           rst_n, enable, issue_valid, retry_valid, retry_ready, clear;
   logic [IDS-1:0] issue_id, retry_id;
   logic           ready_o, rvalid_o, dvalid_o, fatal_o;
   logic [IDS-1:0] rid_o, did_o;
   logic [2:0]     pend_o;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int m_cnt [16];
   int m_q [$];
   bit m_drop;
   int m_drop_id;
   bit m_fatal;

   always #5 clk = ~clk;

   retry_scheduler #(
      .IDSize    (IDS),
      .MaxRetries(MAXR),
      .FifoDepth (DEPTH)
   ) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .enable_i     (enable),
      .issue_id_i   (issue_id),
      .issue_valid_i(issue_valid),
      .retry_id_i   (retry_id),
      .retry_valid_i(retry_valid),
      .retry_ready_o(ready_o),
      .retry_id_o   (rid_o),
      .retry_valid_o(rvalid_o),
      .retry_ready_i(retry_ready),
      .drop_id_o    (did_o),
      .drop_valid_o (dvalid_o),
      .fatal_o      (fatal_o),
      .clear_i      (clear),
      .pending_o    (pend_o)
   );

   // Advance one clock, updating the model from the inputs applied during this cycle.
   task automatic tick();
      bit acc, pp, nd;
      if (!rst_n) begin
         foreach (m_cnt[i]) m_cnt[i] = 0;
         m_q.delete();
         m_drop    = 0;
         m_drop_id = 0;
         m_fatal   = 0;
      end else begin
         acc = retry_valid && (m_q.size() < DEPTH);
         pp  = retry_ready && (m_q.size() > 0);
         nd  = 0;
         if (pp) m_q.delete(0);
         if (acc) begin
            if (issue_valid && issue_id == retry_id) m_q.push_back(int'(retry_id));
            else if (!enable) m_q.push_back(int'(retry_id));
            else if (m_cnt[retry_id] < MAXR) begin
               m_cnt[retry_id]++;
               m_q.push_back(int'(retry_id));
            end else nd = 1;
         end
         if (issue_valid) m_cnt[issue_id] = 0;
         m_drop = nd;
         if (nd) m_drop_id = int'(retry_id);
         if (nd) m_fatal = 1;
         else if (clear) m_fatal = 0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      issue_valid = 0;
      retry_valid = 0;
      clear       = 0;
   endtask

   task automatic test_reset();
      rst_n = 0;
      tick();
      tick();
      rst_n = 1;
      checks++;
      if (rvalid_o !== 1'b0 || rid_o !== 4'd0 || pend_o !== 3'd0) begin
         errors++;
         $display("FAIL reset_queue: valid=%0d id=%0d pending=%0d, required 0 0 0",
                  rvalid_o, rid_o, pend_o);
      end
      checks++;
      if (dvalid_o !== 1'b0 || did_o !== 4'd0 || fatal_o !== 1'b0 || ready_o !== 1'b1) begin
         errors++;
         $display("FAIL reset_flags: drop=%0d drop_id=%0d fatal=%0d ready=%0d, required 0 0 0 1",
                  dvalid_o, did_o, fatal_o, ready_o);
      end
   endtask

   task automatic test_single();
      idle();
      retry_ready = 1;
      issue_valid = 1; issue_id = 3;
      tick();
      issue_valid = 0;
      retry_valid = 1; retry_id = 3;
      tick();
      retry_valid = 0;
      checks++;
      if (rvalid_o !== 1'b1 || rid_o !== 4'd3 || pend_o !== 3'd1) begin
         errors++;
         $display("FAIL single_out: valid=%0d id=%0d pending=%0d, required 1 3 1",
                  rvalid_o, rid_o, pend_o);
      end
      tick();
      checks++;
      if (rvalid_o !== 1'b0 || pend_o !== 3'd0) begin
         errors++;
         $display("FAIL single_drain: valid=%0d pending=%0d, required 0 0", rvalid_o, pend_o);
      end
   endtask

   task automatic test_exhaust();
      int fwd = 0;
      idle();
      retry_ready = 1;
      issue_valid = 1; issue_id = 5;
      tick();
      issue_valid = 0;
      for (int k = 0; k < 4; k++) begin
         retry_valid = 1; retry_id = 5;
         tick();
         if (k < 3) begin
            if (rvalid_o === 1'b1 && rid_o === 4'd5 && dvalid_o === 1'b0) fwd++;
         end else begin
            checks++;
            if (dvalid_o !== 1'b1 || did_o !== 4'd5 || fatal_o !== 1'b1) begin
               errors++;
               $display("FAIL exhaust_drop: drop=%0d id=%0d fatal=%0d, required 1 5 1",
                        dvalid_o, did_o, fatal_o);
            end
         end
      end
      checks++;
      if (fwd !== 3) begin
         errors++;
         $display("FAIL exhaust_forwarded: got %0d, required 3", fwd);
      end
      retry_valid = 0;
      tick();
      tick();
      checks++;
      if (dvalid_o !== 1'b0 || fatal_o !== 1'b1 || pend_o !== 3'd0) begin
         errors++;
         $display("FAIL exhaust_sticky: drop=%0d fatal=%0d pending=%0d, required 0 1 0",
                  dvalid_o, fatal_o, pend_o);
      end
      clear = 1;
      tick();
      clear = 0;
      checks++;
      if (fatal_o !== 1'b0) begin
         errors++;
         $display("FAIL exhaust_clear: fatal=%0d, required 0", fatal_o);
      end
   endtask

   task automatic test_back_to_back();
      int exp_head [4] = '{9, 10, 11, 12};
      int exp_pend [4] = '{3, 3, 2, 1};
      idle();
      retry_ready = 0;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (ready_o !== (i < 4)) begin
            errors++;
            $display("FAIL bp_ready_%0d: ready=%0d, required %0d", i, ready_o, i < 4);
         end
         retry_valid = 1; retry_id = IDS'(8 + i);
         tick();
      end
      checks++;
      if (pend_o !== 3'd4 || ready_o !== 1'b0 || rid_o !== 4'd8) begin
         errors++;
         $display("FAIL bp_full: pending=%0d ready=%0d head=%0d, required 4 0 8",
                  pend_o, ready_o, rid_o);
      end
      retry_ready = 1;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (i == 1) retry_valid = 0;
         checks++;
         if (rid_o !== IDS'(exp_head[i]) || pend_o !== 3'(exp_pend[i])) begin
            errors++;
            $display("FAIL bp_order_%0d: head=%0d pending=%0d, required %0d %0d",
                     i, rid_o, pend_o, exp_head[i], exp_pend[i]);
         end
      end
      tick();
      checks++;
      if (rvalid_o !== 1'b0 || pend_o !== 3'd0) begin
         errors++;
         $display("FAIL bp_empty: valid=%0d pending=%0d, required 0 0", rvalid_o, pend_o);
      end
   endtask

   task automatic test_collision();
      idle();
      retry_ready = 1;
      issue_valid = 1; issue_id = 7;
      tick();
      issue_valid = 0;
      for (int k = 0; k < 3; k++) begin
         retry_valid = 1; retry_id = 7;
         tick();
      end
      issue_valid = 1; issue_id = 7;
      tick();
      issue_valid = 0;
      checks++;
      if (dvalid_o !== 1'b0 || rvalid_o !== 1'b1 || rid_o !== 4'd7) begin
         errors++;
         $display("FAIL collide_push: drop=%0d valid=%0d id=%0d, required 0 1 7",
                  dvalid_o, rvalid_o, rid_o);
      end
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++;
         if (dvalid_o !== (k == 3)) begin
            errors++;
            $display("FAIL collide_budget_%0d: drop=%0d, required %0d", k, dvalid_o, k == 3);
         end
      end
      retry_valid = 0;
      clear = 1;
      tick();
      clear = 0;
      tick();
   endtask

   task automatic test_disabled();
      int fwd = 0;
      int drops = 0;
      idle();
      enable = 0;
      retry_ready = 1;
      for (int k = 0; k < 10; k++) begin
         retry_valid = 1; retry_id = 2;
         tick();
         if (rvalid_o === 1'b1 && rid_o === 4'd2) fwd++;
         if (dvalid_o !== 1'b0) drops++;
      end
      retry_valid = 0;
      enable = 1;
      tick();
      checks++;
      if (fwd !== 10 || drops !== 0 || dvalid_o !== 1'b0) begin
         errors++;
         $display("FAIL disabled: forwarded=%0d drops=%0d, required 10 0", fwd, drops);
      end
   endtask

   task automatic test_reset_mid();
      idle();
      retry_ready = 0;
      issue_valid = 1; issue_id = 9;
      tick();
      issue_valid = 0;
      for (int k = 0; k < 3; k++) begin
         retry_valid = 1; retry_id = 9;
         tick();
      end
      checks++;
      if (pend_o !== 3'd3) begin
         errors++;
         $display("FAIL midrst_queued: pending=%0d, required 3", pend_o);
      end
      rst_n = 0;
      tick();
      rst_n = 1;
      retry_valid = 0;
      checks++;
      if (pend_o !== 3'd0 || rvalid_o !== 1'b0 || fatal_o !== 1'b0 || dvalid_o !== 1'b0) begin
         errors++;
         $display("FAIL midrst_state: pending=%0d valid=%0d fatal=%0d drop=%0d, required 0 0 0 0",
                  pend_o, rvalid_o, fatal_o, dvalid_o);
      end
      tick();
      checks++;
      if (dvalid_o !== 1'b0 || rvalid_o !== 1'b0) begin
         errors++;
         $display("FAIL midrst_nopulse: drop=%0d valid=%0d, required 0 0", dvalid_o, rvalid_o);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         rst_n       = ($urandom_range(63) != 0);
         enable      = ($urandom_range(3) != 0);
         issue_valid = ($urandom_range(3) == 0);
         issue_id    = IDS'($urandom_range(3));
         retry_valid = $urandom_range(1);
         retry_id    = IDS'($urandom_range(3));
         retry_ready = $urandom_range(1);
         clear       = ($urandom_range(15) == 0);
         tick();
         checks++;
         if (pend_o !== 3'(m_q.size()) || rvalid_o !== (m_q.size() > 0)
             || ready_o !== (m_q.size() < DEPTH)
             || (m_q.size() > 0 && rid_o !== IDS'(m_q[0]))) begin
            errors++;
            $display("FAIL rand_queue_%0d: pending=%0d valid=%0d ready=%0d head=%0d, required %0d",
                     n, pend_o, rvalid_o, ready_o, rid_o, m_q.size());
         end
         checks++;
         if (dvalid_o !== m_drop || did_o !== IDS'(m_drop_id) || fatal_o !== m_fatal) begin
            errors++;
            $display("FAIL rand_drop_%0d: drop=%0d id=%0d fatal=%0d, required %0d %0d %0d",
                     n, dvalid_o, did_o, fatal_o, m_drop, m_drop_id, m_fatal);
         end
      end
   endtask

   initial begin
      rst_n = 0; enable = 1; retry_ready = 0; issue_id = 0; retry_id = 0;
      idle();
      test_reset();
      test_single();
      test_exhaust();
      test_back_to_back();
      test_collision();
      test_disabled();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
